// File: rtl/niosii_system_sysid_checker_pkg.sv
// Shared types and constants for the system-ID checker.
// Holds the FSM encoding, slave word addresses and counter widths.
package niosII_system_sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ID_REQ,
        ST_RD_ID_WAIT,
        ST_RD_TS_REQ,
        ST_RD_TS_WAIT,
        ST_CHECK,
        ST_FINISH
    } state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam int TMR_W   = 16;
    localparam int RETRY_W = 4;

    function automatic logic is_req(input state_e s);
        return (s == ST_RD_ID_REQ) || (s == ST_RD_TS_REQ);
    endfunction

    function automatic logic is_wait(input state_e s);
        return (s == ST_RD_ID_WAIT) || (s == ST_RD_TS_WAIT);
    endfunction

endpackage

// File: rtl/niosii_system_sysid_checker_read_timer.sv
// Per-word read timeout counter plus the late-response drop flag.
// The counter saturates at the limit so expiry stays asserted.
module niosII_system_sysid_read_timer
    import niosII_system_sysid_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    input  logic set_drop_i,
    input  logic rdv_i,
    output logic last_o,
    output logic expired_o,
    output logic drop_o
);

    localparam logic [TMR_W-1:0] LIMIT = TMR_W'(TIMEOUT_CYCLES);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;
    logic             drop_q;
    logic             drop_d;

    // Next-state for the cycle counter and the discard-next-response flag
    always_comb begin
        cnt_d  = cnt_q;
        drop_d = drop_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + TMR_W'(1);
        end
        if (set_drop_i) begin
            drop_d = 1'b1;
        end else if (rdv_i) begin
            drop_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
        end
    end

    assign last_o    = (cnt_q == (LIMIT - TMR_W'(1)));
    assign expired_o = (cnt_q == LIMIT);
    assign drop_o    = drop_q;

endmodule

// File: rtl/niosii_system_sysid_checker.sv
// Avalon-MM read master that checks the system-ID and timestamp words
// against build-time values and reports pass/fail with sticky flags.
module niosii_system_sysid_checker
    import niosII_system_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1490562120,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter int unsigned MAX_RETRIES        = 3,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout_err,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts
);

    state_e               state_q;
    logic                 auto_q;
    logic [RETRY_W-1:0]   retry_q;
    logic                 read_q;
    logic                 addr_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 pass_q;
    logic                 id_mm_q;
    logic                 ts_mm_q;
    logic                 to_q;
    logic [31:0]          cap_id_q;
    logic [31:0]          cap_ts_q;

    logic tmr_last;
    logic tmr_expired;
    logic tmr_drop;

    logic go;
    logic in_req;
    logic in_wait;
    logic accept;
    logic rdv_eff;
    logic got;
    logic abandon;
    logic set_drop;
    logic retry_ok;
    logic enter_req;

    // Handshake decode shared by the FSM and the timer
    always_comb begin
        go        = (state_q == ST_IDLE) && (start || auto_q);
        in_req    = is_req(state_q);
        in_wait   = is_wait(state_q);
        accept    = in_req && read_q && !avm_waitrequest;
        rdv_eff   = avm_readdatavalid && !tmr_drop;
        got       = in_wait && rdv_eff;
        abandon   = tmr_expired && ((in_req && !accept) || (in_wait && !rdv_eff));
        set_drop  = tmr_expired && in_wait && !rdv_eff;
        retry_ok  = retry_q < RETRY_W'(MAX_RETRIES);
        enter_req = go
                  || ((state_q == ST_RD_ID_WAIT) && got)
                  || (abandon && retry_ok);
    end

    niosII_system_sysid_read_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .clr_i      (enter_req),
        .en_i       (in_req || in_wait),
        .set_drop_i (set_drop),
        .rdv_i      (avm_readdatavalid),
        .last_o     (tmr_last),
        .expired_o  (tmr_expired),
        .drop_o     (tmr_drop)
    );

    // Check sequencer with registered bus and status outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            auto_q   <= AUTO_START;
            retry_q  <= '0;
            read_q   <= 1'b0;
            addr_q   <= SYSID_ADDR_ID;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            id_mm_q  <= 1'b0;
            ts_mm_q  <= 1'b0;
            to_q     <= 1'b0;
            cap_id_q <= '0;
            cap_ts_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (abandon) begin
                if (retry_ok) begin
                    retry_q <= retry_q + RETRY_W'(1);
                    state_q <= ST_RD_ID_REQ;
                    read_q  <= 1'b1;
                    addr_q  <= SYSID_ADDR_ID;
                end else begin
                    to_q    <= 1'b1;
                    state_q <= ST_FINISH;
                    read_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (go) begin
                            auto_q  <= 1'b0;
                            state_q <= ST_RD_ID_REQ;
                            read_q  <= 1'b1;
                            addr_q  <= SYSID_ADDR_ID;
                            busy_q  <= 1'b1;
                            pass_q  <= 1'b0;
                            id_mm_q <= 1'b0;
                            ts_mm_q <= 1'b0;
                            to_q    <= 1'b0;
                            retry_q <= '0;
                        end
                    end
                    ST_RD_ID_REQ, ST_RD_TS_REQ: begin
                        if (accept) begin
                            read_q  <= 1'b0;
                            state_q <= (state_q == ST_RD_ID_REQ)
                                     ? ST_RD_ID_WAIT : ST_RD_TS_WAIT;
                        end else if (tmr_last) begin
                            read_q <= 1'b0;
                        end
                    end
                    ST_RD_ID_WAIT: begin
                        if (got) begin
                            cap_id_q <= avm_readdata;
                            state_q  <= ST_RD_TS_REQ;
                            read_q   <= 1'b1;
                            addr_q   <= SYSID_ADDR_TS;
                        end
                    end
                    ST_RD_TS_WAIT: begin
                        if (got) begin
                            cap_ts_q <= avm_readdata;
                            state_q  <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        id_mm_q <= (cap_id_q != EXPECTED_ID);
                        ts_mm_q <= (cap_ts_q != EXPECTED_TIMESTAMP);
                        pass_q  <= (cap_id_q == EXPECTED_ID)
                                && (cap_ts_q == EXPECTED_TIMESTAMP);
                        state_q <= ST_FINISH;
                        done_q  <= 1'b1;
                    end
                    ST_FINISH: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        read_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign avm_address = addr_q;
    assign avm_read    = read_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign id_mismatch = id_mm_q;
    assign ts_mismatch = ts_mm_q;
    assign timeout_err = to_q;
    assign captured_id = cap_id_q;
    assign captured_ts = cap_ts_q;

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Bench for the system-ID checker: behavioural Avalon slave with
// configurable stall/latency plus directed and randomized check runs.
module tb_niosii_system_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'd1490562120;
    localparam int          T_OUT  = 10;
    localparam int          MAXR   = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = 32'h0;
    logic        avm_readdatavalid = 1'b0;
    logic        busy;
    logic        done;
    logic        pass;
    logic        id_mismatch;
    logic        ts_mismatch;
    logic        timeout_err;
    logic [31:0] captured_id;
    logic [31:0] captured_ts;

    int nchecks = 0;
    int nerr    = 0;

    // slave configuration (written by the main sequence only)
    int          cfg_stall  = 0;
    int          cfg_lat    = 1;
    bit          cfg_silent = 1'b0;
    logic [31:0] cfg_id     = EXP_ID;
    logic [31:0] cfg_ts     = EXP_TS;
    int          ovr_idx    = -1;
    int          ovr_extra  = 0;
    logic [31:0] ovr_val    = 32'h0;

    // slave state (written by the slave process only)
    int          ncyc       = 0;
    int          age        = 0;
    int          accepts    = 0;
    int          last_due   = 0;
    int          stall_viol = 0;
    bit          prev_wr    = 1'b0;
    logic        prev_addr  = 1'b0;
    int          s_due;
    logic [31:0] s_dat;
    int          due_q[$];
    logic [31:0] dat_q[$];
    logic        acc_addr_q[$];

    niosii_system_sysid_checker #(
        .EXPECTED_ID        (EXP_ID),
        .EXPECTED_TIMESTAMP (EXP_TS),
        .TIMEOUT_CYCLES     (T_OUT),
        .MAX_RETRIES        (MAXR),
        .AUTO_START         (1'b1)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .id_mismatch       (id_mismatch),
        .ts_mismatch       (ts_mismatch),
        .timeout_err       (timeout_err),
        .captured_id       (captured_id),
        .captured_ts       (captured_ts)
    );

    initial forever #5 clock = ~clock;

    // Slave: updates at negedge; responses are returned in order
    initial begin
        forever begin
            @(negedge clock);
            ncyc++;
            if (reset) begin
                due_q.delete();
                dat_q.delete();
                avm_waitrequest   = 1'b0;
                avm_readdatavalid = 1'b0;
                avm_readdata      = 32'h0;
                age     = 0;
                prev_wr = 1'b0;
            end else begin
                if (prev_wr && (avm_read !== 1'b1 || avm_address !== prev_addr))
                    stall_viol++;
                avm_readdatavalid = 1'b0;
                avm_readdata      = 32'h0;
                if (due_q.size() > 0 && due_q[0] == ncyc) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = dat_q[0];
                    void'(due_q.pop_front());
                    void'(dat_q.pop_front());
                end
                if (avm_read === 1'b1) begin
                    if (age < cfg_stall) begin
                        avm_waitrequest = 1'b1;
                        age++;
                    end else begin
                        avm_waitrequest = 1'b0;
                        age = 0;
                        acc_addr_q.push_back(avm_address);
                        if (!cfg_silent) begin
                            s_dat = avm_address ? cfg_ts : cfg_id;
                            s_due = ncyc + cfg_lat;
                            if (accepts == ovr_idx) begin
                                s_dat = ovr_val;
                                s_due = s_due + ovr_extra;
                            end
                            if (s_due <= last_due) s_due = last_due + 1;
                            last_due = s_due;
                            due_q.push_back(s_due);
                            dat_q.push_back(s_dat);
                        end
                        accepts++;
                    end
                end else begin
                    avm_waitrequest = 1'b0;
                    age = 0;
                end
                prev_wr   = avm_waitrequest && (avm_read === 1'b1);
                prev_addr = avm_address;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycles from start sample to done: two words each taking
    // (stall + 1) request cycles and lat wait cycles, then CHECK.
    function automatic int exp_off(input int s, input int l);
        return 2 * (s + 1 + l) + 1;
    endfunction

    task automatic measure(input bit do_start, input int restart_at,
                           input int budget, output int off,
                           output int nd, output logic busy1);
        off   = -1;
        nd    = 0;
        busy1 = 1'b0;
        if (do_start) start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            if (i == restart_at) start = 1'b1;
            @(posedge clock); #1;
            start = 1'b0;
            if (i == 1) busy1 = busy;
            if (done) begin
                nd++;
                if (off < 0) off = i;
            end
        end
    endtask

    task automatic check_result(input string tg, input logic [31:0] eid,
                                input logic [31:0] ets, input bit e_to);
        chk({tg, "_pass"}, 32'(pass),
            32'(!e_to && eid == EXP_ID && ets == EXP_TS));
        chk({tg, "_idmm"}, 32'(id_mismatch), 32'(!e_to && eid != EXP_ID));
        chk({tg, "_tsmm"}, 32'(ts_mismatch), 32'(!e_to && ets != EXP_TS));
        chk({tg, "_tmo"}, 32'(timeout_err), 32'(e_to));
        if (!e_to) begin
            chk({tg, "_capid"}, captured_id, eid);
            chk({tg, "_capts"}, captured_ts, ets);
        end
    endtask

    task automatic check_zero(input string tg);
        chk({tg, "_busy"}, 32'(busy), 0);
        chk({tg, "_done"}, 32'(done), 0);
        chk({tg, "_pass"}, 32'(pass), 0);
        chk({tg, "_flags"}, {29'd0, id_mismatch, ts_mismatch, timeout_err}, 0);
        chk({tg, "_read"}, 32'(avm_read), 0);
        chk({tg, "_addr"}, 32'(avm_address), 0);
        chk({tg, "_capid"}, captured_id, 0);
        chk({tg, "_capts"}, captured_ts, 0);
    endtask

    int          off;
    int          nd;
    logic        b1;
    int          a0;
    int          v0;
    int          s;
    int          l;
    logic [31:0] eid;
    logic [31:0] ets;
    logic [31:0] one = 32'h1;
    bit          found;

    initial begin
        // reset state
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_zero("rst");

        // auto-start run after reset release
        a0 = accepts;
        reset = 1'b0;
        measure(1'b0, 0, 40, off, nd, b1);
        chk("auto_busy", 32'(b1), 1);
        chk("auto_off", off, exp_off(0, 1));
        chk("auto_ndone", nd, 1);
        chk("auto_acc", accepts - a0, 2);
        chk("auto_addr0", 32'(acc_addr_q[a0]), 0);
        chk("auto_addr1", 32'(acc_addr_q[a0 + 1]), 1);
        check_result("auto", EXP_ID, EXP_TS, 1'b0);

        // ID mismatch
        cfg_id = 32'h0000_0001;
        measure(1'b1, 0, 40, off, nd, b1);
        check_result("idmm", 32'h1, EXP_TS, 1'b0);
        chk("idmm_ndone", nd, 1);
        cfg_id = EXP_ID;

        // long waitrequest and data latency
        cfg_stall = 5;
        cfg_lat   = 3;
        a0 = accepts;
        v0 = stall_viol;
        measure(1'b1, 0, 50, off, nd, b1);
        chk("stall_off", off, exp_off(5, 3));
        chk("stall_viol", stall_viol - v0, 0);
        chk("stall_acc", accepts - a0, 2);
        check_result("stall", EXP_ID, EXP_TS, 1'b0);
        cfg_stall = 0;
        cfg_lat   = 1;

        // silent slave: every attempt times out
        cfg_silent = 1'b1;
        a0 = accepts;
        measure(1'b1, 0, 60, off, nd, b1);
        chk("tmo_off", off, (MAXR + 1) * (T_OUT + 1));
        chk("tmo_ndone", nd, 1);
        chk("tmo_acc", accepts - a0, MAXR + 1);
        check_result("tmo", EXP_ID, EXP_TS, 1'b1);
        cfg_silent = 1'b0;

        // reset clears the pending-drop state; auto run follows
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        measure(1'b0, 0, 40, off, nd, b1);
        chk("rerun_off", off, exp_off(0, 1));
        check_result("rerun", EXP_ID, EXP_TS, 1'b0);

        // first ID reply arrives late and must be discarded
        ovr_idx   = accepts;
        ovr_val   = 32'hDEAD_BEEF;
        ovr_extra = 12;
        a0 = accepts;
        measure(1'b1, 0, 60, off, nd, b1);
        chk("late_ndone", nd, 1);
        chk("late_acc", accepts - a0, 3);
        check_result("late", EXP_ID, EXP_TS, 1'b0);
        ovr_idx = -1;

        // randomized words, stalls and latencies
        for (int r = 0; r < 8; r++) begin
            s   = int'($urandom_range(0, 3));
            l   = int'($urandom_range(1, 4));
            eid = ($urandom_range(0, 1) == 0) ? EXP_ID
                : (EXP_ID ^ (one << $urandom_range(0, 31)));
            ets = ($urandom_range(0, 1) == 0) ? EXP_TS
                : (EXP_TS ^ (one << $urandom_range(0, 31)));
            cfg_stall = s;
            cfg_lat   = l;
            cfg_id    = eid;
            cfg_ts    = ets;
            measure(1'b1, 0, 30, off, nd, b1);
            chk($sformatf("rnd%0d_off", r), off, exp_off(s, l));
            chk($sformatf("rnd%0d_ndone", r), nd, 1);
            check_result($sformatf("rnd%0d", r), eid, ets, 1'b0);
        end
        cfg_stall = 0;
        cfg_lat   = 4;
        cfg_id    = EXP_ID;
        cfg_ts    = EXP_TS;

        // reset while waiting for the timestamp word
        a0 = accepts;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!found) begin
                @(posedge clock); #1;
                if (accepts - a0 == 2 && avm_read === 1'b0 && busy === 1'b1)
                    found = 1'b1;
            end
        end
        chk("tswait_reached", 32'(found), 1);
        reset = 1'b1;
        #1;
        check_zero("midrst");
        repeat (2) @(posedge clock);
        #1;
        chk("midrst_hold_busy", 32'(busy), 0);
        chk("midrst_hold_read", 32'(avm_read), 0);
        cfg_lat = 1;
        reset = 1'b0;
        a0 = accepts;
        measure(1'b1, 3, 40, off, nd, b1);
        chk("post_ndone", nd, 1);
        chk("post_acc", accepts - a0, 2);
        chk("post_off", off, exp_off(0, 1));
        check_result("post", EXP_ID, EXP_TS, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/niosii_system_sysid_checker.md
Name: niosII_system_sysid_checker

Overview:
- Avalon-MM read master that queries a system-ID slave, which is a 1-bit address, 32-bit readdata, read-only peripheral.
- Address 0 returns the system ID; address 1 returns the build timestamp.
- The block reads both words, compares them against build-time expected values, and reports pass/fail with per-field flags.
- Sits beside the processor and gates boot, or drives a status LED, when the FPGA image and software build disagree.

Parameters:
EXPECTED_ID, 32'h0000_0000, value required at slave address 0
EXPECTED_TIMESTAMP, 32'd1490562120, value required at slave address 1
TIMEOUT_CYCLES, 255, max cycles from read assertion to readdatavalid per word (1..65535)
MAX_RETRIES, 3, extra full-sequence attempts after a timeout (0..15)
AUTO_START, 1, 1 = run one check automatically after reset release

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to run a check
avm_address  out  1  0 = ID word, 1 = timestamp word
avm_read  out  1  Avalon read request
avm_waitrequest  in  1  slave stall
avm_readdata  in  32  read data
avm_readdatavalid  in  1  read data qualifier
busy  out  1  check sequence in progress
done  out  1  one-cycle pulse when a check completes
pass  out  1  sticky; last check matched both words
id_mismatch  out  1  sticky; ID word differed
ts_mismatch  out  1  sticky; timestamp word differed
timeout_err  out  1  sticky; retries exhausted
captured_id  out  32  last ID word received
captured_ts  out  32  last timestamp word received

Behaviour:
- One clock domain: clock. Reset is asynchronous and active-high on port reset. All registers clear on assertion; deassertion is used as-is, with no internal synchroniser.
- Reset values: every output is 0; state is IDLE; retry and timeout counters are 0.
- States: IDLE, RD_ID_REQ, RD_ID_WAIT, RD_TS_REQ, RD_TS_WAIT, CHECK, FINISH.
- IDLE → RD_ID_REQ on start=1, or on the first cycle after reset when AUTO_START=1. Entering this path clears pass, the mismatch flags, timeout_err and the retry count.
- *_REQ states:
  - avm_read=1; avm_address is 0 (ID) or 1 (TS).
  - Held stable while avm_waitrequest=1.
  - Transfer is accepted in the cycle with avm_read=1 and avm_waitrequest=0; next state is *_WAIT and avm_read drops.
  - Exactly one outstanding read at any time.
- *_WAIT states:
  - On avm_readdatavalid=1, capture avm_readdata into captured_id or captured_ts.
  - Next state: RD_ID_WAIT→RD_TS_REQ, RD_TS_WAIT→CHECK.
  - Data is valid no earlier than the cycle after acceptance.
  - readdatavalid in any other state is ignored, except the drop rule below.
- Timeout:
  - A 16-bit counter clears on entry to *_REQ and increments each cycle in *_REQ/*_WAIT.
  - When it reaches TIMEOUT_CYCLES, the read is abandoned and avm_read drops that cycle.
  - If the abandon occurs in *_WAIT, set drop_next; the next readdatavalid is discarded and clears drop_next.
  - If retry count < MAX_RETRIES: increment it and go to RD_ID_REQ. Otherwise set timeout_err and go to FINISH.
- CHECK (1 cycle):
  - id_mismatch = (captured_id != EXPECTED_ID); ts_mismatch = (captured_ts != EXPECTED_TIMESTAMP).
  - pass = both equal. Full 32-bit compare, no masking.
- FINISH (1 cycle): done=1, then IDLE.
- busy=1 in every state except IDLE.
- start while busy is ignored. start in the FINISH cycle is also ignored; software re-issues it.
- Latency: minimum 6 cycles from start to done pulse with zero-wait, 1-cycle-latency slave (start sample, ID req, ID wait, TS req, TS wait, CHECK; done in FINISH).
- Reset mid-read: the master drops avm_read immediately. It does not wait for the response, and the slave must tolerate this.

Decomposition:
- Package niosII_system_sysid_pkg: state enum, address constants SYSID_ADDR_ID=0 and SYSID_ADDR_TS=1, timeout counter width (16), retry counter width (4).
- One sub-module, niosII_system_sysid_read_timer: timeout counter with clear/enable/expired and the drop_next flag.
- Compare logic stays inline.

Test Plan:
- Slave returns 0 at addr 0 and 1490562120 at addr 1, zero waitrequest, 1-cycle latency, AUTO_START=1 → after reset, busy high; reads at addr 0 then 1; done pulse 6 cycles after first active cycle; pass=1, flags 0, captured_ts=1490562120.
- Slave returns 32'h0000_0001 at addr 0 → id_mismatch=1, ts_mismatch=0, pass=0, captured_id=1.
- waitrequest held 5 cycles on each read, data latency 3 → avm_read/avm_address stable throughout the stall; exactly two accepted transfers; pass=1.
- TIMEOUT_CYCLES=10, MAX_RETRIES=2, slave never asserts readdatavalid → 3 attempts each abandoned after 10 cycles; timeout_err=1, pass=0; one done pulse.
- TIMEOUT_CYCLES=10, first ID response arrives at cycle 14 and later responses are normal → late word discarded; retry succeeds; captured_id is the retry value; pass=1.
- reset pulsed while in RD_TS_WAIT, then start=1 twice (second while busy) → all outputs 0 during reset; exactly one sequence runs; one done pulse.
